// File: rtl/ibex_pkg.sv
// Shared types and widths for the Ibex writeback stage.
package ibex_pkg;

  localparam int unsigned RegAddrW = 5;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_VALID,
    WB_LOAD_WAIT
  } wb_state_e;

endpackage

// File: rtl/ibex_wb_pipe.sv
// Single-entry writeback stage: captures EX results or waits for load data, drives the RF write port.
// Optional bypass outputs enabled by defining IBEX_WB_FWD_EN.
module ibex_wb_pipe
  import ibex_pkg::*;
#(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ex_valid_i,
  input  logic                 en_wb_i,
  input  logic                 instr_is_load_i,
  input  logic                 rf_we_i,
  input  logic [RegAddrW-1:0]  rf_waddr_i,
  input  logic [DataWidth-1:0] result_ex_i,
  input  logic                 lsu_resp_valid_i,
  input  logic [DataWidth-1:0] lsu_rdata_i,
  input  logic                 lsu_err_i,
  output logic                 ready_wb_o,
  output logic                 rf_we_o,
  output logic [RegAddrW-1:0]  rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 instr_done_o,
  output logic                 load_err_o,
  output logic                 fwd_valid_o,
  output logic [RegAddrW-1:0]  fwd_addr_o,
  output logic [DataWidth-1:0] fwd_data_o
);

  wb_state_e              state_q, state_d;
  logic                   we_q, we_d;
  logic [RegAddrW-1:0]    waddr_q, waddr_d;
  logic [DataWidth-1:0]   data_q, data_d;
  logic                   ready;
  logic                   accept;
  logic                   addr_ok;

  // State and capture registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= WB_IDLE;
      we_q    <= 1'b0;
      waddr_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      data_q  <= data_d;
    end
  end

  // Next state, capture and retire/write outputs
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    waddr_d      = waddr_q;
    data_d       = data_q;
    rf_we_o      = 1'b0;
    rf_wdata_o   = '0;
    instr_done_o = 1'b0;
    load_err_o   = 1'b0;
    rf_waddr_o   = waddr_q;

    ready   = (state_q != WB_LOAD_WAIT) | lsu_resp_valid_i;
    accept  = ex_valid_i & en_wb_i & ready;
    addr_ok = (waddr_q != '0) & ~(RV32E & waddr_q[RegAddrW-1]);

    // Whenever the slot frees up, either capture the new instruction or empty out
    if (ready) begin
      if (accept) begin
        state_d = instr_is_load_i ? WB_LOAD_WAIT : WB_VALID;
        we_d    = rf_we_i;
        waddr_d = rf_waddr_i;
        data_d  = instr_is_load_i ? '0 : result_ex_i;
      end else begin
        state_d = WB_IDLE;
        we_d    = 1'b0;
        waddr_d = '0;
        data_d  = '0;
      end
    end

    case (state_q)
      WB_VALID: begin
        instr_done_o = 1'b1;
        rf_we_o      = we_q & addr_ok;
        if (rf_we_o) rf_wdata_o = data_q;
      end
      WB_LOAD_WAIT: begin
        if (lsu_resp_valid_i) begin
          instr_done_o = 1'b1;
          load_err_o   = lsu_err_i;
          rf_we_o      = we_q & ~lsu_err_i & addr_ok;
          if (rf_we_o) rf_wdata_o = lsu_rdata_i;
        end
      end
      default: ;
    endcase
  end

  assign ready_wb_o = ready;

`ifdef IBEX_WB_FWD_EN
  assign fwd_valid_o = rf_we_o;
  assign fwd_addr_o  = rf_waddr_o;
  assign fwd_data_o  = rf_wdata_o;
`else
  assign fwd_valid_o = 1'b0;
  assign fwd_addr_o  = '0;
  assign fwd_data_o  = '0;
`endif

endmodule

// File: tb/tb_ibex_wb_pipe.sv
// Bench for ibex_wb_pipe: directed vector table plus randomized traffic against a queue-based model.
module tb_ibex_wb_pipe;
  import ibex_pkg::*;

  logic        clk;
  logic        rst;
  logic        ex_valid, en_wb, is_load, we_in, resp, err;
  logic [4:0]  waddr_in;
  logic [31:0] result, rdata;

  logic        ready    [2];
  logic        rf_we    [2];
  logic [4:0]  rf_waddr [2];
  logic [31:0] rf_wdata [2];
  logic        done     [2];
  logic        lerr     [2];
  logic        fvalid   [2];
  logic [4:0]  faddr    [2];
  logic [31:0] fdata    [2];

  int checks = 0;
  int errors = 0;

  ibex_wb_pipe #(.RV32E(1'b0), .DataWidth(32)) dut (
    .clk_i(clk), .rst_i(rst), .ex_valid_i(ex_valid), .en_wb_i(en_wb),
    .instr_is_load_i(is_load), .rf_we_i(we_in), .rf_waddr_i(waddr_in),
    .result_ex_i(result), .lsu_resp_valid_i(resp), .lsu_rdata_i(rdata),
    .lsu_err_i(err), .ready_wb_o(ready[0]), .rf_we_o(rf_we[0]),
    .rf_waddr_o(rf_waddr[0]), .rf_wdata_o(rf_wdata[0]), .instr_done_o(done[0]),
    .load_err_o(lerr[0]), .fwd_valid_o(fvalid[0]), .fwd_addr_o(faddr[0]),
    .fwd_data_o(fdata[0])
  );

  ibex_wb_pipe #(.RV32E(1'b1), .DataWidth(32)) dut_e (
    .clk_i(clk), .rst_i(rst), .ex_valid_i(ex_valid), .en_wb_i(en_wb),
    .instr_is_load_i(is_load), .rf_we_i(we_in), .rf_waddr_i(waddr_in),
    .result_ex_i(result), .lsu_resp_valid_i(resp), .lsu_rdata_i(rdata),
    .lsu_err_i(err), .ready_wb_o(ready[1]), .rf_we_o(rf_we[1]),
    .rf_waddr_o(rf_waddr[1]), .rf_wdata_o(rf_wdata[1]), .instr_done_o(done[1]),
    .load_err_o(lerr[1]), .fwd_valid_o(fvalid[1]), .fwd_addr_o(faddr[1]),
    .fwd_data_o(fdata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, exv, en, ld, we;
    logic [4:0]  addr;
    logic [31:0] res;
    logic        resp;
    logic [31:0] rdata;
    logic        err;
    logic        x_ready, x_we, x_we_e;
    logic [4:0]  x_addr;
    logic [31:0] x_data;
    logic        x_done, x_lerr;
  } vec_t;

  // One instruction sitting in writeback, as the model sees it
  typedef struct {
    logic        ld, we;
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t   q[$];
  vec_t   tbl[26];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t v(input logic r, exv, en, ld, we, input logic [4:0] addr,
                             input logic [31:0] res, input logic rs, input logic [31:0] rd,
                             input logic er, input logic xr, xw, xwe, input logic [4:0] xa,
                             input logic [31:0] xd, input logic xdn, xle);
    vec_t t;
    t.rst = r; t.exv = exv; t.en = en; t.ld = ld; t.we = we; t.addr = addr;
    t.res = res; t.resp = rs; t.rdata = rd; t.err = er;
    t.x_ready = xr; t.x_we = xw; t.x_we_e = xwe; t.x_addr = xa; t.x_data = xd;
    t.x_done = xdn; t.x_lerr = xle;
    return t;
  endfunction

  task automatic apply(input logic r, exv, en, ld, we, input logic [4:0] a,
                       input logic [31:0] res, input logic rs, input logic [31:0] rd,
                       input logic er);
    rst = r; ex_valid = exv; en_wb = en; is_load = ld; we_in = we; waddr_in = a;
    result = res; resp = rs; rdata = rd; err = er;
  endtask

  // Compare both instances against the model, then advance the model one clock
  task automatic model_step();
    logic        x_ready, x_we, x_done, x_lerr, ok;
    logic [4:0]  x_addr;
    logic [31:0] x_data;
    ent_t        h;
    for (int i = 0; i < 2; i++) begin
      x_ready = 1'b1; x_we = 1'b0; x_addr = 5'd0; x_data = 32'd0;
      x_done = 1'b0; x_lerr = 1'b0;
      if (q.size() > 0) begin
        h = q[0];
        x_addr = h.addr;
        ok = (h.addr != 5'd0) && !(i == 1 && h.addr >= 5'd16);
        if (!h.ld) begin
          x_done = 1'b1;
          x_we = h.we && ok;
          x_data = x_we ? h.data : 32'd0;
        end else if (resp) begin
          x_done = 1'b1;
          x_lerr = err;
          x_we = h.we && !err && ok;
          x_data = x_we ? rdata : 32'd0;
        end else begin
          x_ready = 1'b0;
        end
      end
      chk($sformatf("m%0d.ready", i), 32'(ready[i]), 32'(x_ready));
      chk($sformatf("m%0d.rf_we", i), 32'(rf_we[i]), 32'(x_we));
      chk($sformatf("m%0d.waddr", i), 32'(rf_waddr[i]), 32'(x_addr));
      chk($sformatf("m%0d.wdata", i), rf_wdata[i], x_data);
      chk($sformatf("m%0d.done", i), 32'(done[i]), 32'(x_done));
      chk($sformatf("m%0d.load_err", i), 32'(lerr[i]), 32'(x_lerr));
`ifdef IBEX_WB_FWD_EN
      chk($sformatf("m%0d.fwd", i), {fdata[i][25:0], faddr[i], fvalid[i]},
          {x_data[25:0], x_addr, x_we});
      chk($sformatf("m%0d.fwd_hi", i), 32'(fdata[i][31:26]), 32'(x_data[31:26]));
`else
      chk($sformatf("m%0d.fwd", i), {fdata[i][25:0], faddr[i], fvalid[i]}, 32'd0);
      chk($sformatf("m%0d.fwd_hi", i), 32'(fdata[i][31:26]), 32'd0);
`endif
    end
    x_ready = (q.size() == 0) || !q[0].ld || resp;
    if (q.size() > 0 && (!q[0].ld || resp)) void'(q.pop_front());
    if (ex_valid && en_wb && x_ready) begin
      h.ld = is_load; h.we = we_in; h.addr = waddr_in; h.data = result;
      q.push_back(h);
    end
    if (rst) q.delete();
  endtask

  initial begin
    // rst exv en ld we addr res resp rdata err | ready we we_e addr data done lerr
    tbl[0]  = v(0,0,0,0,0, 5'd0,  32'h0,        0, 32'h0,    0, 1,0,0, 5'd0,  32'h0,        0,0);
    tbl[1]  = v(0,1,1,0,1, 5'd5,  32'hDEADBEEF, 0, 32'h0,    0, 1,0,0, 5'd0,  32'h0,        0,0);
    tbl[2]  = v(0,0,0,0,0, 5'd0,  32'h0,        0, 32'h0,    0, 1,1,1, 5'd5,  32'hDEADBEEF, 1,0);
    tbl[3]  = v(0,0,0,0,0, 5'd0,  32'h0,        0, 32'h0,    0, 1,0,0, 5'd0,  32'h0,        0,0);
    tbl[4]  = v(0,1,1,1,1, 5'd7,  32'hFFFF,     0, 32'h0,    0, 1,0,0, 5'd0,  32'h0,        0,0);
    tbl[5]  = v(0,0,0,0,0, 5'd0,  32'h0,        0, 32'h0,    0, 0,0,0, 5'd7,  32'h0,        0,0);
    tbl[6]  = v(0,0,0,0,0, 5'd0,  32'h0,        0, 32'h0,    0, 0,0,0, 5'd7,  32'h0,        0,0);
    tbl[7]  = v(0,0,0,0,0, 5'd0,  32'h0,        1, 32'h1234, 0, 1,1,1, 5'd7,  32'h1234,     1,0);
    tbl[8]  = v(0,0,0,0,0, 5'd0,  32'h0,        0, 32'h0,    0, 1,0,0, 5'd0,  32'h0,        0,0);
    tbl[9]  = v(0,1,1,1,1, 5'd9,  32'h0,        0, 32'h0,    0, 1,0,0, 5'd0,  32'h0,        0,0);
    tbl[10] = v(0,0,0,0,0, 5'd0,  32'h0,        1, 32'hAAAA, 1, 1,0,0, 5'd9,  32'h0,        1,1);
    tbl[11] = v(0,1,1,0,1, 5'd0,  32'h55,       0, 32'h0,    0, 1,0,0, 5'd0,  32'h0,        0,0);
    tbl[12] = v(0,1,1,0,1, 5'd20, 32'h77,       0, 32'h0,    0, 1,0,0, 5'd0,  32'h0,        1,0);
    tbl[13] = v(0,0,0,0,0, 5'd0,  32'h0,        0, 32'h0,    0, 1,1,0, 5'd20, 32'h77,       1,0);
    tbl[14] = v(0,1,1,1,1, 5'd3,  32'h0,        0, 32'h0,    0, 1,0,0, 5'd0,  32'h0,        0,0);
    tbl[15] = v(0,1,1,0,1, 5'd4,  32'h2222,     1, 32'h1111, 0, 1,1,1, 5'd3,  32'h1111,     1,0);
    tbl[16] = v(0,0,0,0,0, 5'd0,  32'h0,        0, 32'h0,    0, 1,1,1, 5'd4,  32'h2222,     1,0);
    tbl[17] = v(0,1,1,1,1, 5'd6,  32'h0,        0, 32'h0,    0, 1,0,0, 5'd0,  32'h0,        0,0);
    tbl[18] = v(1,0,0,0,0, 5'd0,  32'h0,        0, 32'h0,    0, 0,0,0, 5'd6,  32'h0,        0,0);
    tbl[19] = v(0,0,0,0,0, 5'd0,  32'h0,        1, 32'h99,   0, 1,0,0, 5'd0,  32'h0,        0,0);
    tbl[20] = v(0,0,1,0,1, 5'd2,  32'h42,       0, 32'h0,    0, 1,0,0, 5'd0,  32'h0,        0,0);
    tbl[21] = v(0,0,0,0,0, 5'd0,  32'h0,        0, 32'h0,    0, 1,0,0, 5'd0,  32'h0,        0,0);
    tbl[22] = v(0,0,0,0,0, 5'd0,  32'h0,        1, 32'h33,   1, 1,0,0, 5'd0,  32'h0,        0,0);
    tbl[23] = v(0,1,1,0,0, 5'd8,  32'h5,        0, 32'h0,    0, 1,0,0, 5'd0,  32'h0,        0,0);
    tbl[24] = v(0,0,0,0,0, 5'd0,  32'h0,        1, 32'h3,    1, 1,0,0, 5'd8,  32'h0,        1,0);
    tbl[25] = v(0,0,0,0,0, 5'd0,  32'h0,        0, 32'h0,    0, 1,0,0, 5'd0,  32'h0,        0,0);

    apply(1, 0,0,0,0, 5'd0, 32'h0, 0, 32'h0, 0);
    repeat (2) @(posedge clk);
    #1;

    for (int r = 0; r < 26; r++) begin
      apply(tbl[r].rst, tbl[r].exv, tbl[r].en, tbl[r].ld, tbl[r].we, tbl[r].addr,
            tbl[r].res, tbl[r].resp, tbl[r].rdata, tbl[r].err);
      @(negedge clk);
      chk($sformatf("v%0d.ready", r), 32'(ready[0]), 32'(tbl[r].x_ready));
      chk($sformatf("v%0d.rf_we", r), 32'(rf_we[0]), 32'(tbl[r].x_we));
      chk($sformatf("v%0d.waddr", r), 32'(rf_waddr[0]), 32'(tbl[r].x_addr));
      chk($sformatf("v%0d.wdata", r), rf_wdata[0], tbl[r].x_we ? tbl[r].x_data : 32'h0);
      chk($sformatf("v%0d.done", r), 32'(done[0]), 32'(tbl[r].x_done));
      chk($sformatf("v%0d.load_err", r), 32'(lerr[0]), 32'(tbl[r].x_lerr));
      chk($sformatf("v%0d.e_rf_we", r), 32'(rf_we[1]), 32'(tbl[r].x_we_e));
      chk($sformatf("v%0d.e_wdata", r), rf_wdata[1], tbl[r].x_we_e ? tbl[r].x_data : 32'h0);
      model_step();
      @(posedge clk);
      #1;
    end

    // Randomized traffic: mixed loads, ALU ops, stray responses and occasional resets
    for (int c = 0; c < 3000; c++) begin
      apply(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
            5'($urandom_range(0, 31)),
            $urandom(),
            ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
            $urandom(),
            ($urandom_range(0, 9) < 2) ? 1'b1 : 1'b0);
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
